// File: rtl/led_ring_ctrl_if.sv
// led_ring_ctrl_if: encoder/button inputs, serialiser handshake and display outputs of the LED ring controller
interface led_ring_ctrl_if #(parameter int NUM_LEDS = 12);
    localparam int POS_W = $clog2(NUM_LEDS);
    logic                rot_up;
    logic                rot_dn;
    logic                push;
    logic [1:0]          intensity_in;
    logic                frame_done;
    logic                refresh;
    logic [NUM_LEDS-1:0] led_mask;
    logic [7:0]          intensity_out;
    logic [POS_W-1:0]    position;
    logic [1:0]          mode;
    logic                busy;
    modport master (
        input  rot_up, rot_dn, push, intensity_in, frame_done,
        output refresh, led_mask, intensity_out, position, mode, busy
    );
    modport slave (
        output rot_up, rot_dn, push, intensity_in, frame_done,
        input  refresh, led_mask, intensity_out, position, mode, busy
    );
endinterface

// File: rtl/led_ring_ctrl.sv
// led_ring_ctrl: rotary cursor/mode tracking with frame-atomic snapshots handed to a WS2812B serialiser
module led_ring_ctrl #(
    parameter int NUM_LEDS = 12,
    localparam int POS_W = $clog2(NUM_LEDS)
) (
    input logic clk,
    input logic res_n,
    led_ring_ctrl_if.master bus
);
    typedef enum logic {IDLE, WAIT} state_t;
    localparam logic [POS_W-1:0] LAST = POS_W'(NUM_LEDS - 1);
    state_t              state;
    logic [POS_W-1:0]    pos;
    logic [POS_W-1:0]    rpos;
    logic [1:0]          mode_q;
    logic [1:0]          int_q;
    logic                dirty;
    logic                step;
    logic                ev;
    logic [NUM_LEDS-1:0] mask_c;
    logic [7:0]          int_map;
    // mode bit 0 selects bar vs dot, bit 1 inverts the pattern
    always_comb begin
        step = bus.rot_up ^ bus.rot_dn;
        ev = step | bus.push | (bus.intensity_in != int_q);
        rpos = LAST - pos;
        mask_c = (mode_q[0] ? ({NUM_LEDS{1'b1}} >> rpos) : (NUM_LEDS'(1) << pos)) ^ {NUM_LEDS{mode_q[1]}};
        int_map = int_q == 2'b00 ? 8'h01 : int_q == 2'b01 ? 8'h02 : int_q == 2'b10 ? 8'h08 : 8'h20;
    end
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
            pos <= '0;
            mode_q <= 2'b00;
            int_q <= 2'b00;
            dirty <= 1'b1;
            bus.refresh <= 1'b0;
            bus.led_mask <= NUM_LEDS'(1);
            bus.intensity_out <= 8'h01;
        end else begin
            int_q <= bus.intensity_in;
            if (step) pos <= bus.rot_up ? (pos == LAST ? '0 : pos + 1'b1) : (pos == '0 ? LAST : pos - 1'b1);
            if (bus.push) mode_q <= mode_q + 2'd1;
            bus.refresh <= 1'b0;
            dirty <= dirty | ev;
            // a new event in the snapshot cycle keeps dirty set for a follow-up frame
            if (state == IDLE && dirty) begin
                bus.refresh <= 1'b1;
                bus.led_mask <= mask_c;
                bus.intensity_out <= int_map;
                dirty <= ev;
                state <= WAIT;
            end else if (state == WAIT && bus.frame_done) begin
                state <= IDLE;
            end
        end
    end
    assign bus.busy = (state == WAIT);
    assign bus.position = pos;
    assign bus.mode = mode_q;
endmodule

// File: doc/led_ring_ctrl.md
Name: led_ring_ctrl

Overview:
Parametrised successor to the 12-LED rotary ring controller. Tracks a wrapping cursor position driven by rotary up/down pulses and cycles four display modes on push. It also maps a 2-bit intensity select to an 8-bit brightness. A refresh handshake FSM snapshots mask and intensity and hands one frame at a time to the WS2812B serialiser, so the driver never sees data change mid-frame.

Parameters:
NUM_LEDS, 12, LEDs on the ring (2..64); mask width and position modulus
POS_W, $clog2(NUM_LEDS), width of position output (derived; do not override)

Ports:
clk  in  1  system clock (40 MHz)
res_n  in  1  reset, asynchronous, active-low
rot_up  in  1  single-cycle step-up pulse from encoder decoder
rot_dn  in  1  single-cycle step-down pulse from encoder decoder
push  in  1  single-cycle debounced button pulse
intensity_in  in  2  brightness select
frame_done  in  1  single-cycle pulse from serialiser: frame fully shifted out
refresh  out  1  single-cycle frame request to serialiser
led_mask  out  NUM_LEDS  snapshot of per-LED on/off, bit i = LED i
intensity_out  out  8  snapshot of brightness value
position  out  POS_W  live cursor position, 0..NUM_LEDS-1
mode  out  2  live display mode
busy  out  1  high while a frame is outstanding (WAIT state)

Behaviour:
- Reset (async assert, sync deassert in the clk domain) sets: position=0, mode=DOT(00), refresh=0, busy=0, led_mask=1, intensity_out=8'h01. FSM=IDLE. dirty=1, so the first frame is sent after reset.
- Position update on the clock edge of the event cycle:
  - rot_up only: pos = (pos==NUM_LEDS-1) ? 0 : pos+1.
  - rot_dn only: pos = (pos==0) ? NUM_LEDS-1 : pos-1.
  - Both rot_up and rot_dn high: no change, dirty not set.
- Mode on push: DOT(00) -> BAR(01) -> DOT_INV(10) -> BAR_INV(11) -> DOT. push is independent of rot_*, so both may apply in the same cycle.
- Intensity map: 00->8'h01, 01->8'h02, 10->8'h08, 11->8'h20. intensity_in is registered once (int_q). A change of the mapped value sets dirty.
- Mask function of (pos, mode), computed combinationally internally:
  - DOT: only bit pos set.
  - BAR: bits 0..pos set.
  - *_INV: bitwise inverse of the non-inverted pattern over NUM_LEDS bits.
- dirty is set on any accepted position change, mode change or intensity change.
- FSM states: IDLE, WAIT.
  - IDLE and dirty=1: on the next edge, drive refresh=1 for exactly one cycle, latch led_mask and intensity_out from the current pos/mode/int_q, clear dirty, go to WAIT, busy=1.
  - If a new event occurs in that same cycle, dirty remains set (set wins over clear).
  - WAIT: led_mask and intensity_out are held stable. Events still update position/mode and set dirty.
  - WAIT and frame_done=1: go to IDLE, busy=0.
  - IDLE and dirty=0: outputs hold.
  - frame_done in IDLE is ignored.
- Latency: an event in cycle N changes position/mode at N+1. If FSM is IDLE at N+1, refresh is high at N+2 with the matching snapshot. With back-to-back frames, the minimum gap from frame_done to the next refresh is 2 cycles.
- Multiple events during WAIT coalesce into one follow-up frame that carries the latest state.
- Reset mid-frame returns to IDLE with dirty=1; the serialiser is reset by the same res_n.

Test Plan:
- Release reset with frame_done tied off -> refresh pulse 2 cycles after deassert, led_mask=12'h001, intensity_out=8'h01, busy=1 until frame_done.
- NUM_LEDS=12: 12 rot_up pulses with frame_done returned each frame -> position 1..11,0, led_mask 12'h002..12'h800,12'h001. One rot_dn at pos 0 -> position 11, led_mask 12'h800.
- pos=4, push x1 -> BAR, mask 12'h01F. push x2 total -> DOT_INV, mask 12'hFEF. push x3 total -> BAR_INV, mask 12'hFE0. push x4 total -> DOT, mask 12'h010.
- In WAIT, issue 3 rot_up pulses and intensity_in 00->11 -> led_mask/intensity_out unchanged until frame_done. Then exactly one refresh with position+3 mask and intensity_out=8'h20.
- rot_up and rot_dn asserted in the same cycle -> position unchanged, no refresh issued.
- Assert res_n low asynchronously during WAIT at pos=7 -> outputs reset immediately without a clock edge. Refresh again after release. Repeat with NUM_LEDS=5 and NUM_LEDS=64 for wrap at 4->0 and 63->0.
